// File: rtl/rom_load_serializer_if.sv
// ROM download bus: bridge write side, halfword stream side and load status.
interface rom_load_serializer_if #(
  parameter int unsigned ADDR_W = 25
);
  logic              dl_start;
  logic              dl_end;
  logic [31:0]       rom_file_size;
  logic              bridge_wr;
  logic [31:0]       bridge_addr;
  logic [31:0]       bridge_wr_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       data;
  logic              downloading;
  logic              overflow;

  // Driver of the download (bridge + downstream ready)
  modport master (
    output dl_start, dl_end, rom_file_size, bridge_wr, bridge_addr, bridge_wr_data, out_ready,
    input  out_valid, addr, data, downloading, overflow
  );

  // The serializer itself
  modport slave (
    input  dl_start, dl_end, rom_file_size, bridge_wr, bridge_addr, bridge_wr_data, out_ready,
    output out_valid, addr, data, downloading, overflow
  );
endinterface

// File: rtl/rom_load_serializer.sv
// Buffers 32-bit ROM download writes and replays them as a little-endian
// halfword stream, trimming halfwords past the file size.
module rom_load_serializer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 25
) (
  input  logic                  clk_mem,
  input  logic                  reset_n,
  rom_load_serializer_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned WA_W  = ADDR_W - 2;
  localparam int unsigned ENT_W = WA_W + 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;

  logic              out_valid_q;
  logic              h_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic [WA_W-1:0]   cur_waddr_q;
  logic [31:0]       cur_word_q;
  logic              downloading_q;
  logic              overflow_q;

  logic              fifo_empty_c, fifo_full_c;
  logic [ENT_W-1:0]  head_c;
  logic [WA_W-1:0]   head_waddr_c;
  logic [31:0]       head_word_c;
  logic [ADDR_W-1:0] head_lo_addr_c, hi_addr_c;
  logic              lo_ok_c, hi_ok_c;
  logic              xfer_c, stage_free_c, pop_c, push_c, drop_c, start_c;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{bus.bridge_addr[31:ADDR_W], bus.bridge_addr[1:0]};

  // FIFO status and head entry
  assign fifo_empty_c   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_c    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                          (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_c         = mem[rd_ptr_q[PTR_W-1:0]];
  assign head_waddr_c   = head_c[ENT_W-1:32];
  assign head_word_c    = head_c[31:0];

  // Tail trim: a halfword is presented only if its address lies inside the file
  assign head_lo_addr_c = {head_waddr_c, 2'b00};
  assign hi_addr_c      = {cur_waddr_q, 2'b10};
  assign lo_ok_c        = 32'(head_lo_addr_c) < bus.rom_file_size;
  assign hi_ok_c        = 32'(hi_addr_c) < bus.rom_file_size;

  // Handshake and FIFO control; a full FIFO can still accept when it pops in the same cycle
  assign xfer_c       = out_valid_q && bus.out_ready;
  assign stage_free_c = !out_valid_q || (xfer_c && (h_q || !hi_ok_c));
  assign pop_c        = stage_free_c && !fifo_empty_c && (state_q != S_IDLE);
  assign push_c       = bus.bridge_wr && (state_q == S_ACTIVE) && (!fifo_full_c || pop_c);
  assign drop_c       = bus.bridge_wr && (state_q == S_ACTIVE) && fifo_full_c && !pop_c;
  assign start_c      = (state_q == S_IDLE) && bus.dl_start;

  // Load framing state register
  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: IDLE -> ACTIVE -> DRAIN -> IDLE once the stream is fully drained
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.dl_start) state_d = bus.dl_end ? S_DRAIN : S_ACTIVE;
      S_ACTIVE: if (bus.dl_end) state_d = S_DRAIN;
      S_DRAIN:  if (fifo_empty_c && !out_valid_q && !xfer_c) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FIFO storage (no reset needed; pointers qualify contents)
  always_ff @(posedge clk_mem) begin
    if (push_c) mem[wr_ptr_q[PTR_W-1:0]] <= {bus.bridge_addr[ADDR_W-1:2], bus.bridge_wr_data};
  end

  // FIFO pointers, cleared at the start of each load
  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (start_c) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  // Output stage: holds one word, steps low half then high half
  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      h_q         <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cur_waddr_q <= '0;
      cur_word_q  <= '0;
    end else if (start_c) begin
      out_valid_q <= 1'b0;
      h_q         <= 1'b0;
    end else if (pop_c) begin
      cur_waddr_q <= head_waddr_c;
      cur_word_q  <= head_word_c;
      h_q         <= 1'b0;
      out_valid_q <= lo_ok_c;
      addr_q      <= head_lo_addr_c;
      data_q      <= {head_word_c[23:16], head_word_c[31:24]};
    end else if (xfer_c) begin
      if (!h_q && hi_ok_c) begin
        h_q    <= 1'b1;
        addr_q <= hi_addr_c;
        data_q <= {cur_word_q[7:0], cur_word_q[15:8]};
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Sticky overflow, cleared when a new load starts
  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n)     overflow_q <= 1'b0;
    else if (start_c) overflow_q <= 1'b0;
    else if (drop_c)  overflow_q <= 1'b1;
  end

  // Download framing level, one cycle behind the state
  always_ff @(posedge clk_mem or negedge reset_n) begin
    if (!reset_n) downloading_q <= 1'b0;
    else          downloading_q <= (state_q != S_IDLE);
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.addr        = addr_q;
  assign bus.data        = data_q;
  assign bus.downloading = downloading_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_rom_load_serializer.sv
// Self-checking bench for rom_load_serializer: directed load scenarios plus a
// randomized stream checked against a halfword scoreboard.
module tb_rom_load_serializer;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DEPTH  = 4;

  logic clk_mem = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk_mem = ~clk_mem;

  rom_load_serializer_if #(.ADDR_W(ADDR_W)) bus ();

  rom_load_serializer #(.FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_mem (clk_mem),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [15:0]       d;
  } hw_t;

  hw_t               exp_q[$];
  int                n_cmp = 0;
  int                n_bad = 0;
  int                n_xfer = 0;
  bit                rand_ready = 1'b0;
  bit                hold_prev = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [15:0]       prev_data;
  logic [31:0]       size_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
    return w[31-8*k -: 8];
  endfunction

  // Reference: a word covers 4 bytes; each in-file halfword is {byte a+1, byte a}
  task automatic model_write(input logic [31:0] ba, input logic [31:0] w);
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] a;
    hw_t e;
    base = ba[ADDR_W-1:0] & ~ADDR_W'(3);
    for (int h = 0; h < 2; h++) begin
      a = base + ADDR_W'(2*h);
      if (32'(a) < size_m) begin
        e.a = a;
        e.d = {byte_of(w, 2*h+1), byte_of(w, 2*h)};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wr(input logic [31:0] ba, input logic [31:0] w, input bit accepted);
    bus.bridge_wr      = 1'b1;
    bus.bridge_addr    = ba;
    bus.bridge_wr_data = w;
    if (accepted) model_write(ba, w);
  endtask

  // One clock: observe at negedge, then advance and drop pulses
  task automatic cyc();
    hw_t e;
    @(negedge clk_mem);
    if (hold_prev) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_addr", 32'(bus.addr), 32'(prev_addr));
      chk("hold_data", 32'(bus.data), 32'(prev_data));
    end
    if (bus.out_valid && bus.out_ready) begin
      chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("xfer_addr", 32'(bus.addr), 32'(e.a));
        chk("xfer_data", 32'(bus.data), 32'(e.d));
      end
      chk("dl_at_xfer", 32'(bus.downloading), 32'd1);
      n_xfer++;
    end
    hold_prev = bus.out_valid && !bus.out_ready;
    prev_addr = bus.addr;
    prev_data = bus.data;
    @(posedge clk_mem);
    #1;
    bus.dl_start  = 1'b0;
    bus.dl_end    = 1'b0;
    bus.bridge_wr = 1'b0;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_load(input logic [31:0] sz);
    size_m            = sz;
    bus.rom_file_size = sz;
    bus.dl_start      = 1'b1;
    cyc();
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && (bus.downloading || exp_q.size() != 0); i++) cyc();
    chk({tag, "_dl_low"}, 32'(bus.downloading), 32'd0);
    chk({tag, "_all_seen"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int hi_cnt;
    bus.dl_start = 0; bus.dl_end = 0; bus.rom_file_size = 0;
    bus.bridge_wr = 0; bus.bridge_addr = 0; bus.bridge_wr_data = 0;
    bus.out_ready = 1'b1;
    size_m = 0;

    // Reset values
    repeat (2) @(posedge clk_mem);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_addr", 32'(bus.addr), 32'd0);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_dl", 32'(bus.downloading), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    reset_n = 1'b1;
    cyc();

    // Writes in IDLE are ignored
    wr(32'h0000_0010, 32'hDEADBEEF, 1'b0);
    cyc(); cyc(); cyc();
    chk("idle_wr_ignored", 32'(bus.out_valid), 32'd0);

    // 1: single word, latency and byte order; then an address with high bits set
    start_load(32'h0100_0000);
    wr(32'h0000_0000, 32'h11223344, 1'b1);
    cyc();
    #3 chk("t1_valid_c1", 32'(bus.out_valid), 32'd0);
    cyc();
    #3 chk("t1_valid_c2", 32'(bus.out_valid), 32'd1);
    chk("t1_addr0", 32'(bus.addr), 32'h0);
    chk("t1_data0", 32'(bus.data), 32'h2211);
    cyc();
    #3 chk("t1_addr2", 32'(bus.addr), 32'h2);
    chk("t1_data2", 32'(bus.data), 32'h4433);
    cyc();
    wr(32'hF200_0004, 32'hA1B2C3D4, 1'b1);
    bus.dl_end = 1'b1;
    cyc();
    drain("t1", 50);

    // 2: stall keeps output stable; FIFO takes 4 more, 5th overflows
    bus.out_ready = 1'b0;
    start_load(32'h0100_0000);
    wr(32'h0000_0100, 32'h0102_0304, 1'b1);
    cyc();
    for (int i = 0; i < 11; i++) cyc();
    chk("t2_stalled_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      wr(32'h0000_0100 + 32'(4*i), $urandom, 1'b1);
      cyc();
    end
    #3 chk("t2_ovf_after4", 32'(bus.overflow), 32'd0);
    wr(32'h0000_0200, 32'hFFFF_FFFF, 1'b0);
    cyc();
    #3 chk("t2_ovf_after5", 32'(bus.overflow), 32'd1);
    bus.out_ready = 1'b1;
    bus.dl_end = 1'b1;
    cyc();
    drain("t2", 60);
    chk("t2_ovf_sticky", 32'(bus.overflow), 32'd1);

    // 3: size 6 -> halfwords at 0, 2, 4; exact fall of downloading
    start_load(32'd6);
    chk("t3_ovf_cleared", 32'(bus.overflow), 32'd0);
    wr(32'h0, 32'hCAFEF00D, 1'b1);
    cyc();
    wr(32'h4, 32'h5566_7788, 1'b1);
    bus.dl_end = 1'b1;
    cyc();
    n0 = n_xfer;
    for (int i = 0; i < 30 && n_xfer < n0 + 3; i++) cyc();
    chk("t3_count", 32'(n_xfer - n0), 32'd3);
    #3 chk("t3_dl_k1", 32'(bus.downloading), 32'd1);
    cyc();
    #3 chk("t3_dl_k2", 32'(bus.downloading), 32'd1);
    cyc();
    #3 chk("t3_dl_k3", 32'(bus.downloading), 32'd0);
    chk("t3_no_extra", 32'(exp_q.size()), 32'd0);

    // 4: randomized stream across 0x8000 with random ready and odd size trim
    rand_ready = 1'b1;
    start_load(32'h0000_80FD);
    for (logic [31:0] a = 32'h7F00; a <= 32'h8100; a += 4) begin
      for (int g = 0; g < 200 && exp_q.size() > 6; g++) cyc();
      chk("t4_pace", 32'(exp_q.size() <= 6), 32'd1);
      if ($urandom_range(0, 3) == 0) cyc();
      wr(a, $urandom, 1'b1);
      if (a == 32'h8100) bus.dl_end = 1'b1;
      cyc();
    end
    drain("t4", 2000);
    chk("t4_no_ovf", 32'(bus.overflow), 32'd0);
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;

    // 5: reset mid-stream, then a clean restart
    bus.out_ready = 1'b0;
    start_load(32'h0100_0000);
    for (int i = 0; i < 6; i++) begin
      wr(32'h0000_0400 + 32'(4*i), $urandom, 1'b1);
      cyc();
    end
    #3 chk("t5_pre_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_pre_ovf", 32'(bus.overflow), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_dl", 32'(bus.downloading), 32'd0);
    chk("t5_rst_ovf", 32'(bus.overflow), 32'd0);
    exp_q.delete();
    hold_prev = 1'b0;
    @(posedge clk_mem);
    #1 reset_n = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    start_load(32'h0100_0000);
    wr(32'h0000_0020, 32'h9ABC_DEF0, 1'b1);
    bus.dl_end = 1'b1;
    cyc();
    drain("t5", 50);

    // 6: empty load, downloading high briefly
    bus.dl_end = 1'b1;
    start_load(32'h0100_0000);
    hi_cnt = 0;
    n0 = n_xfer;
    for (int i = 0; i < 6; i++) begin
      #3 if (bus.downloading) hi_cnt++;
      cyc();
    end
    chk("t6_dl_brief", 32'((hi_cnt >= 1) && (hi_cnt <= 2)), 32'd1);
    chk("t6_dl_low", 32'(bus.downloading), 32'd0);
    chk("t6_no_xfer", 32'(n_xfer - n0), 32'd0);
    chk("t6_no_valid", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
